audio_mixer: RTL

AUDIO_MIXER -- requirements
Module: audio_mixer

---
 rtl/audio_mix_pkg.sv | 29 ++
 rtl/audio_mixer_sync_rise.sv | 38 +++
 rtl/audio_mixer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/audio_mix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_mix_pkg
// Description : Shared types and constants for the four-channel audio mixer.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_mix_pkg;

  // Width of one synth channel sample and of the mixed output samples
  localparam int c_SAMPLE_W  = 16;
  // Default volume width (2**(VOL_W-1) is unity gain) and accumulator width
  localparam int c_VOL_W_DEF = 8;
  localparam int c_ACC_W_DEF = 19;
  // Output clamp limits
  localparam int c_SAT_MAX   = 32767;
  localparam int c_SAT_MIN   = -32768;

  // Mixer sequencing: one shared multiply per MAC state, then clamp/write
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC0 = 3'd1,
    ST_MAC1 = 3'd2,
    ST_MAC2 = 3'd3,
    ST_MAC3 = 3'd4,
    ST_SAT  = 3'd5
  } mix_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_mixer_sync_rise.sv
`default_nettype none
// ============================================================================
// Module      : sync_rise
// Description : Two-flop synchronizer followed by a rising-edge detector.
//               All three flops reset to RST_VAL so a level already present at
//               reset release is not mistaken for an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_rise #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  // Synchronizer chain plus one cycle of history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_hist <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign rise = r_sync & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/audio_mixer.sv
`default_nettype none
// ============================================================================
// Module      : audio_mixer
// Description : Four-channel volume mixer. A codec sample request captures the
//               channels, four MAC cycles share one multiplier (a,c -> left,
//               b,d -> right), then the sums are clamped to 16 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_mixer
  import audio_mix_pkg::*;
#(
  parameter int VOL_W = c_VOL_W_DEF,
  parameter int ACC_W = c_ACC_W_DEF
) (
  input  logic                         clk32,
  input  logic                         rst,
  input  logic signed [c_SAMPLE_W-1:0] channel_a,
  input  logic signed [c_SAMPLE_W-1:0] channel_b,
  input  logic signed [c_SAMPLE_W-1:0] channel_c,
  input  logic signed [c_SAMPLE_W-1:0] channel_d,
  input  logic        [VOL_W-1:0]      vol_a,
  input  logic        [VOL_W-1:0]      vol_b,
  input  logic        [VOL_W-1:0]      vol_c,
  input  logic        [VOL_W-1:0]      vol_d,
  input  logic                         mute_i,
  input  logic                         sample_clk_i,
  output logic signed [c_SAMPLE_W-1:0] left_o,
  output logic signed [c_SAMPLE_W-1:0] right_o,
  output logic                         valid_o,
  output logic        [1:0]            sat_o,
  output logic        [7:0]            overrun_cnt_o,
  output logic                         busy_o
);

  // Signed channel times zero-extended volume fits exactly in this width
  localparam int c_PROD_W = c_SAMPLE_W + VOL_W + 1;
  localparam logic signed [ACC_W-1:0]      c_ACC_MAX = ACC_W'(c_SAT_MAX);
  localparam logic signed [ACC_W-1:0]      c_ACC_MIN = ACC_W'(c_SAT_MIN);
  localparam logic signed [c_SAMPLE_W-1:0] c_OUT_MAX = c_SAMPLE_W'(c_SAT_MAX);
  localparam logic signed [c_SAMPLE_W-1:0] c_OUT_MIN = c_SAMPLE_W'(c_SAT_MIN);

  mix_state_t r_state;
  mix_state_t w_next_state;

  logic                         w_req;
  logic                         w_capture;
  logic                         w_sat_en;
  logic signed [c_SAMPLE_W-1:0] r_ch_a, r_ch_b, r_ch_c, r_ch_d;
  logic        [VOL_W-1:0]      r_vol_a, r_vol_b, r_vol_c, r_vol_d;
  logic signed [ACC_W-1:0]      r_acc_l, r_acc_r;
  logic signed [c_SAMPLE_W-1:0] w_mul_ch;
  logic        [VOL_W-1:0]      w_mul_vol;
  logic signed [c_PROD_W-1:0]   w_mul_a, w_mul_b, w_prod, w_prod_sh;
  logic signed [ACC_W-1:0]      w_term;
  logic                         w_clip_l_hi, w_clip_l_lo, w_clip_r_hi, w_clip_r_lo;
  logic signed [c_SAMPLE_W-1:0] w_left_sat, w_right_sat;
  logic signed [c_SAMPLE_W-1:0] r_left, r_right;
  logic                         r_valid;
  logic        [1:0]            r_sat;
  logic        [7:0]            r_overrun;

  sync_rise #(
    .RST_VAL (1'b1)
  ) u_sync_rise (
    .clk  (clk32),
    .rst  (rst),
    .d    (sample_clk_i),
    .rise (w_req)
  );

  // State register
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and control decode
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_sat_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_capture    = 1'b1;
          w_next_state = ST_MAC0;
        end
      end
      ST_MAC0: w_next_state = ST_MAC1;
      ST_MAC1: w_next_state = ST_MAC2;
      ST_MAC2: w_next_state = ST_MAC3;
      ST_MAC3: w_next_state = ST_SAT;
      ST_SAT: begin
        w_sat_en     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand select for the single shared multiplier
  always_comb begin
    w_mul_ch  = r_ch_a;
    w_mul_vol = r_vol_a;
    case (r_state)
      ST_MAC1: begin w_mul_ch = r_ch_b; w_mul_vol = r_vol_b; end
      ST_MAC2: begin w_mul_ch = r_ch_c; w_mul_vol = r_vol_c; end
      ST_MAC3: begin w_mul_ch = r_ch_d; w_mul_vol = r_vol_d; end
      default: begin w_mul_ch = r_ch_a; w_mul_vol = r_vol_a; end
    endcase
  end

  // Scale by volume; the arithmetic shift floors toward minus infinity
  assign w_mul_a   = c_PROD_W'(w_mul_ch);
  assign w_mul_b   = $signed({{(c_PROD_W-VOL_W){1'b0}}, w_mul_vol});
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_prod_sh = w_prod >>> (VOL_W - 1);
  assign w_term    = ACC_W'(w_prod_sh);

  // Clamp the accumulated sums to the 16-bit output range
  assign w_clip_l_hi = (r_acc_l > c_ACC_MAX);
  assign w_clip_l_lo = (r_acc_l < c_ACC_MIN);
  assign w_clip_r_hi = (r_acc_r > c_ACC_MAX);
  assign w_clip_r_lo = (r_acc_r < c_ACC_MIN);
  assign w_left_sat  = w_clip_l_hi ? c_OUT_MAX :
                       w_clip_l_lo ? c_OUT_MIN : r_acc_l[c_SAMPLE_W-1:0];
  assign w_right_sat = w_clip_r_hi ? c_OUT_MAX :
                       w_clip_r_lo ? c_OUT_MIN : r_acc_r[c_SAMPLE_W-1:0];

  // Holding registers and accumulators; inputs are only sampled at capture
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      r_ch_a  <= '0; r_ch_b  <= '0; r_ch_c  <= '0; r_ch_d  <= '0;
      r_vol_a <= '0; r_vol_b <= '0; r_vol_c <= '0; r_vol_d <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (w_capture) begin
      r_ch_a  <= channel_a; r_ch_b  <= channel_b;
      r_ch_c  <= channel_c; r_ch_d  <= channel_d;
      r_vol_a <= vol_a;     r_vol_b <= vol_b;
      r_vol_c <= vol_c;     r_vol_d <= vol_d;
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (r_state == ST_MAC0 || r_state == ST_MAC2) begin
      r_acc_l <= r_acc_l + w_term;
    end else if (r_state == ST_MAC1 || r_state == ST_MAC3) begin
      r_acc_r <= r_acc_r + w_term;
    end
  end

  // Output write, valid pulse and sticky clamp flags
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      r_left  <= '0;
      r_right <= '0;
      r_valid <= 1'b0;
      r_sat   <= 2'b00;
    end else begin
      r_valid <= w_sat_en;
      if (w_sat_en) begin
        if (mute_i) begin
          r_left  <= '0;
          r_right <= '0;
        end else begin
          r_left  <= w_left_sat;
          r_right <= w_right_sat;
          r_sat   <= r_sat | {(w_clip_r_hi | w_clip_r_lo),
                              (w_clip_l_hi | w_clip_l_lo)};
        end
      end
    end
  end

  // Count requests that arrive while a computation is in flight
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      r_overrun <= 8'd0;
    end else if (w_req && (r_state != ST_IDLE) && (r_overrun != 8'hFF)) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

  assign left_o        = r_left;
  assign right_o       = r_right;
  assign valid_o       = r_valid;
  assign sat_o         = r_sat;
  assign overrun_cnt_o = r_overrun;
  assign busy_o        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
